// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the round engine.
// State bytes are column-major: byte (row r, col c) sits at bits [127-8*(4c+r) -: 8].
package aes_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_eng_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] s, input int r, input int c);
        return s[127 - 8 * (4 * c + r) -: 8];
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_round_engine_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (unless final), AddRoundKey.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] rk,
    input  logic         final_round,
    output logic [127:0] state_out
);

    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;

    always_comb begin
        sb = '0;
        sr = '0;
        mc = '0;
        for (int i = 0; i < 16; i++) begin
            sb[127 - 8 * i -: 8] = SBOX[state_in[127 - 8 * i -: 8]];
        end
        // Row r rotates left by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127 - 8 * (4 * c + r) -: 8] = get_byte(sb, r, (c + r) % 4);
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[127 - 32 * c -: 32] = mix_column(sr[127 - 32 * c -: 32]);
        end
        state_out = (final_round ? sr : mc) ^ rk;
    end

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryptor, one round per clock, valid/ready on both sides.
// Optional AES_BLOCK_CNT_EN adds a 32-bit count of delivered blocks (blk_count).
module aes_round_engine
    import aes_pkg::*;
#(
    parameter  int NR   = 10,
    localparam int RK_W = 128 * (NR + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RK_W-1:0] round_keys,
    input  logic            key_ready,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [127:0]    plaintext,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [127:0]    ciphertext,
    output logic            busy
`ifdef AES_BLOCK_CNT_EN
    ,
    output logic [31:0]     blk_count
`endif
);

    if (NR != 10) begin : g_bad_nr
        $error("aes_round_engine supports only NR = 10");
    end

    localparam logic [3:0] LAST_RND = 4'(NR);

    aes_eng_state_t fsm_q;
    logic [3:0]     rnd_q;
    logic [127:0]   state_q;
    logic [127:0]   ciphertext_q;
    logic           out_valid_q;
    logic [127:0]   rk_arr [NR+1];
    logic [127:0]   round_out;

    for (genvar i = 0; i <= NR; i++) begin : g_rk
        assign rk_arr[i] = round_keys[RK_W - 1 - 128 * i -: 128];
    end

    aes_round u_round (
        .state_in    (state_q),
        .rk          (rk_arr[rnd_q]),
        .final_round (rnd_q == LAST_RND),
        .state_out   (round_out)
    );

    assign in_ready   = (fsm_q == IDLE) && key_ready;
    assign out_valid  = out_valid_q;
    assign ciphertext = ciphertext_q;
    assign busy       = (fsm_q != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q        <= IDLE;
            rnd_q        <= '0;
            state_q      <= '0;
            ciphertext_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    if (in_valid && key_ready) begin
                        state_q <= plaintext ^ rk_arr[0];
                        rnd_q   <= 4'd1;
                        fsm_q   <= ROUND;
                    end
                end
                ROUND: begin
                    if (!key_ready) begin
                        // Key withdrawn mid-block: drop it silently.
                        fsm_q <= IDLE;
                        rnd_q <= '0;
                    end else begin
                        state_q <= round_out;
                        if (rnd_q == LAST_RND) begin
                            rnd_q        <= '0;
                            fsm_q        <= DONE;
                            out_valid_q  <= 1'b1;
                            ciphertext_q <= round_out;
                        end else begin
                            rnd_q <= rnd_q + 4'd1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        fsm_q       <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

`ifdef AES_BLOCK_CNT_EN
    logic [31:0] blk_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_count_q <= '0;
        end else if (out_valid_q && out_ready) begin
            blk_count_q <= blk_count_q + 32'd1;
        end
    end

    assign blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine using FIPS-197 vectors; round keys expanded locally.
module tb_aes_round_engine;

    localparam logic [7:0] TB_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] R0_2 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] R1_2 = 128'ha49c7ff2689f352b6b5bea43026a5049;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [1407:0]  round_keys = '0;
    logic           key_ready = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [127:0]   plaintext = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [127:0]   ciphertext;
    logic           busy;
`ifdef AES_BLOCK_CNT_EN
    logic [31:0]    blk_count;
`endif

    int total = 0;
    int bad = 0;
    logic [1407:0] rk1, rk2;

    always #5 clk = ~clk;

    aes_round_engine dut (
        .clk        (clk),
        .reset      (reset),
        .round_keys (round_keys),
        .key_ready  (key_ready),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
`ifdef AES_BLOCK_CNT_EN
        ,
        .blk_count  (blk_count)
`endif
    );

    function automatic logic [1407:0] expand_key(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] res;
        rc = 8'h01;
        res = '0;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {TB_SBOX[t[31:24]], TB_SBOX[t[23:16]], TB_SBOX[t[15:8]], TB_SBOX[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) res[1407 - 32 * i -: 32] = w[i];
        return res;
    endfunction

    // Stimulus only: accept one block, then count edges until out_valid (-1 on timeout).
    task automatic do_block(input logic [127:0] pt, output int lat);
        in_valid = 1'b1;
        plaintext = pt;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || ciphertext !== 128'h0) begin
            bad++;
            $display("FAIL reset_outputs: got ov=%b busy=%b ct=%h want 0 0 0", out_valid, busy, ciphertext);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_ready_nokey: got %b want 0", in_ready);
        end
`ifdef AES_BLOCK_CNT_EN
        total++;
        if (blk_count !== 32'h0) begin
            bad++;
            $display("FAIL reset_blk_count: got %h want 0", blk_count);
        end
`endif
        key_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready_key: got %b want 1", in_ready);
        end
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_vector1();
        int lat;
        round_keys = rk1;
        do_block(P1, lat);
        total++;
        if (lat !== 10) begin
            bad++;
            $display("FAIL v1_latency: got %0d want 10", lat);
        end
        total++;
        if (ciphertext !== C1) begin
            bad++;
            $display("FAIL v1_ciphertext: got %h want %h", ciphertext, C1);
        end
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL v1_done_flags: got busy=%b in_ready=%b want 1 0", busy, in_ready);
        end
        do_handshake();
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL v1_idle_after: got ov=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_fips_round1();
        int lat;
        round_keys = rk2;
        in_valid = 1'b1;
        plaintext = P2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (dut.state_q !== R0_2) begin
            bad++;
            $display("FAIL fips_round0_state: got %h want %h", dut.state_q, R0_2);
        end
        @(posedge clk); #1;
        total++;
        if (dut.state_q !== R1_2) begin
            bad++;
            $display("FAIL fips_round1_state: got %h want %h", dut.state_q, R1_2);
        end
        lat = -1;
        for (int i = 2; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        total++;
        if (lat !== 10 || ciphertext !== C2) begin
            bad++;
            $display("FAIL fips_ciphertext: got lat=%0d ct=%h want 10 %h", lat, ciphertext, C2);
        end
        do_handshake();
    endtask

    task automatic test_back_to_back();
        int lat;
        int unstable = 0;
        round_keys = rk1;
        do_block(P1, lat);
        in_valid = 1'b1;
        plaintext = P2;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || ciphertext !== C1 || in_ready !== 1'b0) unstable++;
        end
        total++;
        if (unstable != 0) begin
            bad++;
            $display("FAIL hold_stable: got %0d unstable cycles want 0", unstable);
        end
        plaintext = P1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_release: got ov=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL next_accept: got busy=%b want 1", busy);
        end
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        total++;
        if (lat !== 10 || ciphertext !== C1) begin
            bad++;
            $display("FAIL next_block: got lat=%0d ct=%h want 10 %h", lat, ciphertext, C1);
        end
        do_handshake();
    endtask

    task automatic test_key_ready();
        int seen = 0;
        round_keys = rk1;
        key_ready = 1'b0;
        in_valid = 1'b1;
        plaintext = P1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL nokey_in_ready: got %b want 0", in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL nokey_no_accept: got busy=%b want 0", busy);
        end
        key_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        key_ready = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: got busy=%b ov=%b want 0 0", busy, out_valid);
        end
        key_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen++;
        end
        total++;
        if (seen != 0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_no_output: got %0d valid cycles in_ready=%b want 0 1", seen, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        round_keys = rk1;
        in_valid = 1'b1;
        plaintext = P1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || ciphertext !== 128'h0) begin
            bad++;
            $display("FAIL midreset_async: got busy=%b ov=%b ct=%h want 0 0 0", busy, out_valid, ciphertext);
        end
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        do_block(P1, lat);
        total++;
        if (lat !== 10 || ciphertext !== C1) begin
            bad++;
            $display("FAIL midreset_rerun: got lat=%0d ct=%h want 10 %h", lat, ciphertext, C1);
        end
        do_handshake();
    endtask

`ifdef AES_BLOCK_CNT_EN
    task automatic test_blk_count();
        int lat;
        round_keys = rk1;
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        for (int b = 0; b < 3; b++) begin
            do_block(P1, lat);
            do_handshake();
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        key_ready = 1'b0;
        @(posedge clk); #1;
        key_ready = 1'b1;
        total++;
        if (blk_count !== 32'd3) begin
            bad++;
            $display("FAIL blk_count_three: got %0d want 3", blk_count);
        end
        force dut.blk_count_q = 32'hffffffff;
        #1;
        release dut.blk_count_q;
        do_block(P1, lat);
        do_handshake();
        total++;
        if (blk_count !== 32'h0) begin
            bad++;
            $display("FAIL blk_count_wrap: got %h want 0", blk_count);
        end
    endtask
`endif

    initial begin
        rk1 = expand_key(K1);
        rk2 = expand_key(K2);
        test_reset();
        test_vector1();
        test_fips_round1();
        test_back_to_back();
        test_key_ready();
        test_reset_mid();
`ifdef AES_BLOCK_CNT_EN
        test_blk_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
